pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 121 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a registered in_ready (main + skid entry).
// Macro SKID_BUF_EN enables the skid entry; without it the block is a single-entry register.
module pipe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_q & out_ready;
    assign out_valid = main_valid_q;
    // A bubble must never carry live control bits downstream.
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign out_data  = main_data_q;

`ifdef SKID_BUF_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    // in_ready comes straight from a flop, breaking the out_ready -> in_ready path.
    assign in_ready  = ~skid_valid_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_fire || !main_valid_q) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = in_fire;
                if (in_fire) begin
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready  = ~main_valid_q | out_ready;
    assign occupancy = {1'b0, main_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (out_fire || !main_valid_q) begin
            main_valid_d = in_fire;
            if (in_fire) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end
        end
    end
`endif

    // Flush clears only valids so out_data keeps showing the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg; adapts expected depth to SKID_BUF_EN.
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 9;
`ifdef SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    logic [CTRL_W+DATA_W-1:0] q[$];
    int total = 0;
    int bad   = 0;
    logic last_in_fire;
    int accepted;

    pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        logic ifire;
        logic ofire;
        logic [CTRL_W+DATA_W-1:0] exp;
        #1;
        ifire = in_valid & in_ready;
        ofire = out_valid & out_ready;
        if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
        if (flush) begin
            q.delete();
        end else begin
            if (ofire) begin
                chk("out_has_word", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    exp = q.pop_front();
                    chk("out_word", 64'({out_ctrl, out_data}), 64'(exp));
                end
            end
            if (ifire) q.push_back({in_ctrl, in_data});
        end
        last_in_fire = ifire && !flush;
        @(posedge clk);
        #1;
        chk("occ_model", 64'(occupancy), 64'(q.size()));
        @(negedge clk);
    endtask

    task automatic fill(input logic [DATA_W-1:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = base + DATA_W'(i);
            in_ctrl  = CTRL_W'(i + 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_occ",       64'(occupancy), 64'(0));
        chk("rst_out_ctrl",  64'(out_ctrl),  64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // single word latency
        in_valid = 1'b1; in_data = 32'h1234_5678; in_ctrl = 9'h1FF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_out_valid", 64'(out_valid), 64'(1));
        chk("lat_out_data",  64'(out_data),  64'h1234_5678);
        chk("lat_out_ctrl",  64'(out_ctrl),  64'h1FF);
        chk("lat_occ",       64'(occupancy), 64'(1));
        tick();

        // back-pressure: A then B
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1; in_ctrl = 9'h011;
        tick();
        in_data = 32'h2; in_ctrl = 9'h022;
        tick();
        chk("full_occ",      64'(occupancy), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready),  64'(0));
        out_ready = 1'b1;
        in_valid  = (DEPTH == 1);
        chk("head_a", 64'(out_data), 64'h1);
        tick();
        in_valid = 1'b0;
        chk("head_b",       64'(out_data), 64'h2);
        chk("after_occ",    64'(occupancy), 64'(1));
        chk("after_ready",  64'(in_ready),  64'(1));
        tick();
        chk("drained_occ",  64'(occupancy), 64'(0));

        // flush with simultaneous input
        fill(32'hA0);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; in_ctrl = 9'h155;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_ctrl",  64'(out_ctrl),  64'(0));
        chk("flush_occ",   64'(occupancy), 64'(0));
        chk("flush_data",  64'(out_data),  64'hA0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // asynchronous reset while holding words
        fill(32'hB0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready",  64'(in_ready),  64'(1));
        chk("arst_occ",       64'(occupancy), 64'(0));
        chk("arst_out_data",  64'(out_data),  64'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 9'h003; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(out_valid), 64'(1));
        chk("post_rst_data",  64'(out_data),  64'h55);
        chk("post_rst_occ",   64'(occupancy), 64'(1));
        out_ready = 1'b1;
        tick();

        // random streams
        accepted = 0;
        for (int c = 0; c < 20000 && accepted < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_ctrl   = CTRL_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_in_fire) accepted++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) tick();
        chk("rand_accepted", 64'(accepted), 64'(1000));
        chk("rand_drained",  64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
